// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the overflow timer
// Contents: state_t (IDLE/RUN/PAUSE/DONE), mode constants, overflow counter width.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam int OVF_CNT_W = 8;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing one tick every div+1 enabled clocks
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clr       clears the prescaler counter (start/stop)
//   en        counting enable; the counter freezes while low
//   div       latched prescale divisor
//   tick      combinational, high on the enabled clock where the counter equals div
module tick_gen #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/overflow_timer.sv
// rtl/overflow_timer.sv - prescaled down-counter with one-shot/auto-reload overflow pulse
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      pulse: latch mode/prescale/period and (re)start counting
//   stop       pulse: abort to IDLE, clearing count and prescaler
//   pause      level: freeze counting while high
//   mode       0 one-shot, 1 auto-reload (sampled on start)
//   prescale   tick every prescale+1 clocks (sampled on start)
//   period     overflow after period+1 ticks (sampled on start)
//   overflow   registered single-cycle pulse
//   busy       high in RUN or PAUSE
//   done       high in DONE
//   count      current down-count value
//   ovf_cnt    overflows since last start, saturating
module overflow_timer
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 mode,
  input  logic [PRESC_W-1:0]   prescale,
  input  logic [CNT_W-1:0]     period,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     count,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);

  state_t             state, state_n;
  logic               mode_q;
  logic [PRESC_W-1:0] prescale_q;
  logic [CNT_W-1:0]   period_q;
  logic               tick_en;
  logic               tick;
  logic               ovf_tick;

  // Counting also proceeds on the edge that leaves PAUSE, so a pause costs
  // exactly as many clocks as pause was sampled high.
  assign tick_en  = (state == ST_RUN || state == ST_PAUSE) && !pause && !stop && !start;
  assign ovf_tick = tick && (count == '0);

  tick_gen #(
    .PRESC_W(PRESC_W)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (start || stop),
    .en  (tick_en),
    .div (prescale_q),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (stop) begin
      state_n = ST_IDLE;
    end else if (start) begin
      state_n = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_n = ST_PAUSE;
          end else if (ovf_tick && mode_q == MODE_ONESHOT) begin
            state_n = ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_n = (ovf_tick && mode_q == MODE_ONESHOT) ? ST_DONE : ST_RUN;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      count      <= '0;
      ovf_cnt    <= '0;
      mode_q     <= MODE_ONESHOT;
      prescale_q <= '0;
      period_q   <= '0;
    end else begin
      overflow <= 1'b0;
      if (stop) begin
        count <= '0;
      end else if (start) begin
        mode_q     <= mode;
        prescale_q <= prescale;
        period_q   <= period;
        count      <= period;
        ovf_cnt    <= '0;
      end else if (tick) begin
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          overflow <= 1'b1;
          if (ovf_cnt != '1) begin
            ovf_cnt <= ovf_cnt + 1'b1;
          end
          count <= (mode_q == MODE_RELOAD) ? period_q : '0;
        end
      end
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_PAUSE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_overflow_timer.sv
// tb/tb_overflow_timer.sv - randomized and directed bench for overflow_timer
module tb_overflow_timer;

  localparam int CNT_W   = 32;
  localparam int PRESC_W = 16;

  logic               clk = 1'b0;
  logic               rst, start, stop, pause, mode;
  logic [PRESC_W-1:0] prescale;
  logic [CNT_W-1:0]   period;
  logic               overflow, busy, done;
  logic [CNT_W-1:0]   count;
  logic [7:0]         ovf_cnt;

  overflow_timer #(
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .mode    (mode),
    .prescale(prescale),
    .period  (period),
    .overflow(overflow),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
  endtask

  // Reference model: tracks the number of active (non-paused) clocks since
  // start and derives ticks, count and overflows from it arithmetically.
  bit     m_run, m_done, m_mode, m_ovf;
  longint m_s, m_p, m_a, m_count, m_oc;

  task automatic model_edge();
    longint len, t;
    m_ovf = 1'b0;
    if (rst) begin
      m_run = 0; m_done = 0; m_count = 0; m_oc = 0; m_a = 0;
      m_mode = 0; m_s = 0; m_p = 0;
    end else if (stop) begin
      m_run = 0; m_done = 0; m_count = 0;
    end else if (start) begin
      m_mode = mode; m_s = prescale; m_p = period;
      m_run = 1; m_done = 0; m_a = 0; m_count = m_p; m_oc = 0;
    end else if (m_run && !pause) begin
      m_a++;
      len = (m_p + 1) * (m_s + 1);
      t = m_a / (m_s + 1);
      m_count = m_p - (t % (m_p + 1));
      if (m_a % len == 0) begin
        m_ovf = 1'b1;
        m_oc = (m_a / len > 255) ? 255 : m_a / len;
        if (!m_mode) begin
          m_run = 0; m_done = 1; m_count = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("overflow", overflow, m_ovf);
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("count", count, m_count);
    check("ovf_cnt", ovf_cnt, m_oc);
  endtask

  task automatic do_start(input bit md, input int s, input int p);
    mode = md; prescale = PRESC_W'(s); period = CNT_W'(p);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  int k;
  longint frozen;

  initial begin
    rst = 1'b1; start = 0; stop = 0; pause = 0; mode = 0; prescale = '0; period = '0;
    m_run = 0; m_done = 0; m_mode = 0; m_ovf = 0;
    m_s = 0; m_p = 0; m_a = 0; m_count = 0; m_oc = 0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("reset_count", count, 0);
    check("reset_busy", busy, 0);

    // auto-reload, prescale 0, period 4: pulses every 5 clocks
    do_start(1, 0, 4);
    repeat (16) cycle();
    check("t1_ovf_cnt", ovf_cnt, 3);

    // one-shot, prescale 3, period 4: single overflow after 20 clocks
    do_start(0, 3, 4);
    repeat (25) cycle();
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_count", count, 0);
    check("t2_ovf_cnt", ovf_cnt, 1);

    // every-cycle overflow, ovf_cnt saturation
    do_start(1, 0, 0);
    repeat (300) cycle();
    check("t3_ovf_cnt_sat", ovf_cnt, 255);
    check("t3_overflow", overflow, 1);

    // pause for 7 clocks delays overflow by 7
    do_start(1, 1, 9);
    repeat (6) cycle();
    pause = 1'b1;
    cycle();
    frozen = count;
    repeat (6) cycle();
    check("t4_frozen_start", frozen, 6);
    check("t4_frozen_end", count, 6);
    pause = 1'b0;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (overflow) begin
        k = i;
        break;
      end
    end
    check("t4_delay", k, 14);

    // start coincident with due overflow tick
    do_start(1, 0, 2);
    repeat (2) cycle();
    do_start(1, 0, 5);
    check("t5_start_no_ovf", overflow, 0);
    check("t5_start_count", count, 5);
    repeat (5) cycle();
    do_stop();
    check("t5_stop_no_ovf", overflow, 0);
    check("t5_stop_count", count, 0);
    check("t5_stop_busy", busy, 0);

    // reset mid-run at count 3
    do_start(1, 0, 9);
    repeat (6) cycle();
    check("t6_count_before", count, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_rst_count", count, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ovf_cnt", ovf_cnt, 0);
    repeat (20) cycle();

    // randomized control traffic
    for (int i = 0; i < 4000; i++) begin
      start = 0; stop = 0; rst = 0;
      if ($urandom_range(0, 999) < 3) rst = 1'b1;
      else if ($urandom_range(0, 99) < 1) stop = 1'b1;
      else if ($urandom_range(0, 99) < 3) begin
        start = 1'b1;
        mode = 1'($urandom_range(0, 1));
        prescale = PRESC_W'($urandom_range(0, 3));
        period = CNT_W'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6));
      end
      if ($urandom_range(0, 99) < 6) pause = ~pause;
      cycle();
    end
    start = 0; stop = 0; rst = 0; pause = 0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/overflow_timer.md
# overflow_timer

Programmable prescaled down-counter that generates the single-cycle `overflow` pulse consumed by the LED stretcher (`trigger` input) and by any other overflow-driven logic in the lab design. It sits upstream of the blinker. Software-style controls (start/stop/pause, one-shot or auto-reload) come from switches or a control FSM. The block is fully synchronous to `clk` and emits at most one overflow pulse per prescaled period.

## Interface
- `CNT_W`, default 32: width of period and count.
- `PRESC_W`, default 16: width of prescale divisor.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  pulse; loads configuration and (re)starts counting.
- `stop`  in  1  pulse; aborts to IDLE.
- `pause`  in  1  level; freezes counting while high in RUN.
- `mode`  in  1  0 = one-shot, 1 = auto-reload; sampled on start.
- `prescale`  in  PRESC_W  tick every prescale+1 clocks; sampled on start.
- `period`  in  CNT_W  reload value; overflow after period+1 ticks; sampled on start.
- `overflow`  out  1  registered one-cycle pulse.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  high in DONE (one-shot finished).
- `count`  out  CNT_W  current down-count value.
- `ovf_cnt`  out  8  overflows since last start, saturating at 255.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset values: state IDLE; `overflow` 0, `busy` 0, `done` 0, `count` 0, `ovf_cnt` 0; prescaler counter 0; latched mode/prescale/period 0.
- Priority per edge: rst > stop > start > pause > tick.
- `stop` from any state goes to IDLE. It clears `count` and the prescaler. `ovf_cnt` holds.
- `start` from any state goes to RUN:
  - latches `mode`, `prescale`, `period`;
  - sets `count` to `period`;
  - clears the prescaler and `ovf_cnt`.
- RUN:
  - the prescaler counts 0..prescale_q; tick when it equals prescale_q, then wraps to 0;
  - on a tick with count≠0, count decrements;
  - on a tick with count==0, `overflow` is 1 the next cycle and `ovf_cnt` increments, saturating at 255;
  - on that overflow tick, auto-reload sets count to period_q and stays in RUN;
  - on that overflow tick, one-shot goes to DONE with count 0.
- `pause` high in RUN moves to PAUSE. Prescaler and count freeze, and no tick occurs on that edge.
- `pause` low in PAUSE returns to RUN, and counting resumes from the frozen values.
- `start` during PAUSE goes to RUN. `pause` is re-evaluated on the following edge.
- In DONE, `done` is 1 and `count` holds 0 until start, stop or rst.
- period=0 means an overflow on every tick. prescale=0 means a tick every clock.
- `count` wraps never; it is reloaded only at zero. The prescaler compare is on equality with the latched value.

## Timing
- Start at edge E0 gives the first `overflow` high in the cycle after edge E0 + (period+1)·(prescale+1).
- Auto-reload gives pulses spaced exactly (period+1)·(prescale+1) clocks apart.
- `overflow` is always exactly one cycle wide, even with period=0 and prescale=0. The pulse recurs every cycle while the configuration requires it.
- `start` coincident with an overflow tick wins: no overflow pulse, and the counter restarts.
- `stop` coincident with a tick: no overflow.
- Reset mid-run returns all outputs to reset values on the next cycle.
- A PAUSE interval extends the time to overflow by exactly the number of paused cycles.

## Structure
- Shared package `timer_pkg`:
  - state enum (IDLE/RUN/PAUSE/DONE);
  - mode constants MODE_ONESHOT=0, MODE_RELOAD=1;
  - `OVF_CNT_W`=8.
- Sub-module `tick_gen` holds the prescaler counter.
  - Ports: clk, rst, clr, en, div (PRESC_W), tick.
  - `tick` is combinational: en && cnt==div.
- The top level holds the FSM, down-counter, overflow register and saturating counter.

## Test plan
- prescale=0, period=4, mode=1 → overflow pulses 5 clocks after start, then every 5 clocks. Each pulse is 1 cycle wide and `ovf_cnt` counts 1,2,3….
- prescale=3, period=4, mode=0 → one overflow 20 clocks after start. Then `done`=1, `busy`=0, `count`=0, and no further pulses.
- prescale=0, period=0, mode=1 → `overflow` high every cycle from the 2nd cycle after start. After 300 cycles, `ovf_cnt` saturates at 255.
- prescale=1, period=9, pause high for 7 cycles mid-run → overflow delayed by exactly 7 clocks versus the unpaused run. `count` is frozen during the pause.
- start or stop asserted on the same edge as a due overflow tick → no overflow pulse. Start restarts with count=period; stop gives IDLE with count=0.
- rst asserted mid-run (count=3) → next cycle all outputs are 0 and state is IDLE, with no overflow until a new start.
